// File: rtl/rca_ft_pkg.sv
// rca_ft_pkg: shared constants and types for the ripple-carry adder
// checker slice (state encoding, MISR taps, window length rule).
package rca_ft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] POLY_DEF     = 8'h1D;
    localparam logic [4:0] LEN_ZERO_CNT = 5'd16;
    localparam logic [4:0] ERR_MAX      = 5'd31;

    // len=0 encodes a full 16-vector window
    function automatic logic [4:0] len_to_cnt(input logic [3:0] l);
        return (l == 4'd0) ? LEN_ZERO_CNT : {1'b0, l};
    endfunction

endpackage

// File: rtl/rca_ft_chk_if.sv
// rca_ft_chk_if: one vector bus between the adder under test and the
// checker (operands, returned sum/carry and a valid qualifier).
interface rca_ft_chk_if #(
    parameter int W = 4
);
    logic         vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         cout;

    modport master (output vld, a, b, s, cout);
    modport slave  (input  vld, a, b, s, cout);
endinterface

// File: rtl/rca_ft_misr.sv
// rca_ft_misr: Galois-style multiple-input signature register folding
// one parallel word per enabled cycle.
import rca_ft_pkg::*;

module rca_ft_misr #(
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
    input  logic             clk,
    input  logic             init,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_fb;

    assign w_fb = r_sig[SIG_W-1] ? POLY : '0;
    assign sig  = r_sig;

    // shift, fold taps on MSB, absorb the new word
    always_ff @(posedge clk) begin
        if (init || clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= (r_sig << 1) ^ w_fb ^ din;
        end
    end
endmodule

// File: rtl/rca_ft_chk.sv
// rca_ft_chk: windowed checker for an adder under test; counts
// mismatches against a+b, latches the first bad operands, signs {cout,s}.
import rca_ft_pkg::*;

module rca_ft_chk #(
    parameter int               W     = 4,
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [3:0]       len,
    rca_ft_chk_if.slave      bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [W-1:0]     first_a,
    output logic [W-1:0]     first_b,
    output logic [SIG_W-1:0] sig
);
    state_t       r_state;
    state_t       w_next;
    logic [4:0]   r_cnt;
    logic [4:0]   r_err;
    logic [W-1:0] r_fa;
    logic [W-1:0] r_fb;
    logic         w_load;
    logic         w_acc;
    logic         w_bad;
    logic [W:0]   w_gold;
    logic [W:0]   w_got;
    logic [SIG_W-1:0] w_din;

    assign w_load = (r_state != ST_RUN) && start;
    assign w_acc  = (r_state == ST_RUN) && bus.vld;
    assign w_gold = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_got  = {bus.cout, bus.s};
    assign w_bad  = (w_gold != w_got);
    assign w_din  = SIG_W'(w_got);

    assign err_cnt = r_err;
    assign first_a = r_fa;
    assign first_b = r_fb;

    // state register
    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state: start opens a window, last accepted vector closes it
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (bus.vld && r_cnt == 5'd1) w_next = ST_DONE;
            ST_DONE: if (start) w_next = ST_RUN;
            default: w_next = ST_IDLE;
        endcase
    end

    // state-decoded status outputs
    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
        pass = (r_state == ST_DONE) && (r_err == 5'd0);
    end

    // window counter, error count and first-mismatch capture
    always_ff @(posedge clk) begin
        if (init) begin
            r_cnt <= '0;
            r_err <= '0;
            r_fa  <= '0;
            r_fb  <= '0;
        end else if (w_load) begin
            r_cnt <= len_to_cnt(len);
            r_err <= '0;
            r_fa  <= '0;
            r_fb  <= '0;
        end else if (w_acc) begin
            r_cnt <= r_cnt - 5'd1;
            if (w_bad) begin
                if (r_err == 5'd0) begin
                    r_fa <= bus.a;
                    r_fb <= bus.b;
                end
                if (r_err != ERR_MAX) begin
                    r_err <= r_err + 5'd1;
                end
            end
        end
    end

    rca_ft_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk  (clk),
        .init (init),
        .clr  (w_load),
        .en   (w_acc),
        .din  (w_din),
        .sig  (sig)
    );
endmodule

// File: tb/tb_rca_ft_chk.sv
// tb_rca_ft_chk: directed plus random stimulus against a window-level
// reference model of the adder checker.
module tb_rca_ft_chk;
    localparam int W     = 4;
    localparam int SIG_W = 8;
    localparam int POLYV = 'h1D;

    logic         clk = 1'b0;
    logic         init, start;
    logic [3:0]   len;
    logic         busy, done, pass;
    logic [4:0]   err_cnt;
    logic [W-1:0] first_a, first_b;
    logic [SIG_W-1:0] sig;

    rca_ft_chk_if #(.W(W)) bus ();

    rca_ft_chk #(.W(W), .SIG_W(SIG_W)) dut (
        .clk     (clk),
        .init    (init),
        .start   (start),
        .len     (len),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .first_a (first_a),
        .first_b (first_b),
        .sig     (sig)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 run, 2 done
    int m_mode = 0;
    int m_rem  = 0;
    int m_err  = 0;
    int m_fa   = 0;
    int m_fb   = 0;
    int m_sig  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int i_init, input int i_start,
                              input int i_len, input int i_vld,
                              input int i_a, input int i_b,
                              input int i_s, input int i_c);
        int gold, got, ns;
        if (i_init != 0) begin
            m_mode = 0; m_rem = 0; m_err = 0;
            m_fa = 0; m_fb = 0; m_sig = 0;
        end else if (m_mode != 1) begin
            if (i_start != 0) begin
                m_mode = 1;
                m_rem = (i_len == 0) ? 16 : i_len;
                m_err = 0; m_fa = 0; m_fb = 0; m_sig = 0;
            end
        end else if (i_vld != 0) begin
            gold = i_a + i_b;
            got = i_c * (1 << W) + i_s;
            if (gold != got) begin
                if (m_err == 0) begin
                    m_fa = i_a;
                    m_fb = i_b;
                end
                if (m_err < 31) m_err++;
            end
            ns = (m_sig << 1) & ((1 << SIG_W) - 1);
            if (m_sig >= (1 << (SIG_W - 1))) ns = ns ^ POLYV;
            m_sig = ns ^ got;
            m_rem--;
            if (m_rem == 0) m_mode = 2;
        end
    endtask

    task automatic compare_all();
        chk("busy", busy, (m_mode == 1) ? 1 : 0);
        chk("done", done, (m_mode == 2) ? 1 : 0);
        chk("pass", pass, (m_mode == 2 && m_err == 0) ? 1 : 0);
        chk("err_cnt", err_cnt, m_err);
        chk("first_a", first_a, m_fa);
        chk("first_b", first_b, m_fb);
        chk("sig", sig, m_sig);
    endtask

    task automatic cyc(input int i_init, input int i_start, input int i_len,
                       input int i_vld, input int i_a, input int i_b,
                       input int i_s, input int i_c);
        init     = i_init[0];
        start    = i_start[0];
        len      = i_len[3:0];
        bus.vld  = i_vld[0];
        bus.a    = i_a[W-1:0];
        bus.b    = i_b[W-1:0];
        bus.s    = i_s[W-1:0];
        bus.cout = i_c[0];
        @(posedge clk);
        model_edge(i_init, i_start, i_len, i_vld, i_a, i_b, i_s, i_c);
        #1;
        compare_all();
    endtask

    task automatic good_vec(input int a, input int b);
        int r;
        r = a + b;
        cyc(0, 0, 0, 1, a, b, r % 16, r / 16);
    endtask

    initial begin
        int a, b, r, cnt;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_sig", sig, 0);

        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 3, 8, 0);
        chk("d1_done", done, 1);
        chk("d1_pass", pass, 1);
        chk("d1_sig", sig, 'h08);

        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 15, 1, 0, 1);
        chk("d2_pass", pass, 1);
        chk("d2_sig", sig, 'h10);

        cyc(0, 1, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 10, 5, 14, 0);
        cyc(0, 0, 0, 1, 11, 5, 1, 1);
        chk("d3_err", err_cnt, 2);
        chk("d3_fa", first_a, 10);
        chk("d3_fb", first_b, 5);
        chk("d3_pass", pass, 0);
        cyc(0, 0, 0, 1, 1, 1, 0, 0);
        chk("d3_hold", err_cnt, 2);

        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        while (cnt < 16) begin
            if ($urandom_range(0, 2) == 0) begin
                cyc(0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                good_vec($urandom_range(0, 15), $urandom_range(0, 15));
                cnt++;
                if (cnt < 16) chk("d4_notdone", done, 0);
            end
        end
        chk("d4_done", done, 1);
        chk("d4_pass", pass, 1);

        cyc(0, 1, 8, 0, 0, 0, 0, 0);
        good_vec(1, 2);
        cyc(0, 0, 0, 1, 3, 3, 0, 0);
        cyc(0, 1, 3, 1, 2, 2, 4, 0);
        chk("d5_busy", busy, 1);
        chk("d5_err", err_cnt, 1);
        cyc(1, 1, 1, 1, 4, 4, 0, 0);
        chk("d5_busy0", busy, 0);
        chk("d5_err0", err_cnt, 0);
        chk("d5_fa0", first_a, 0);
        chk("d5_sig0", sig, 0);
        cyc(0, 0, 0, 1, 4, 4, 0, 0);
        chk("d5_idle", busy, 0);

        for (int i = 0; i < 600; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            r = a + b;
            if ($urandom_range(0, 4) == 0) r = $urandom_range(0, 31);
            cyc(($urandom_range(0, 99) == 0) ? 1 : 0,
                ($urandom_range(0, 5) == 0) ? 1 : 0,
                $urandom_range(0, 15),
                ($urandom_range(0, 9) < 7) ? 1 : 0,
                a, b, r % 16, r / 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
